// File: rtl/seq_detect_ctrl.sv
// Sequencer that streams an 8-bit pattern MSB-first into an external sequence
// detector, one bit per accepted tick, and counts the detector's hits.
module seq_detect_ctrl (
    input  logic       cp,
    input  logic       rd,
    input  logic       start,
    input  logic       tick,
    input  logic [7:0] pattern,
    input  logic       z_in,
    output logic       x,
    output logic       det_step,
    output logic       det_clr,
    output logic       busy,
    output logic       done,
    output logic [2:0] bit_idx,
    output logic [3:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] pat_reg;
    logic       pend_reg;
    logic       phase_reg;
    logic       x_reg;
    logic       step_reg;
    logic       clr_reg;
    logic [2:0] idx_reg;
    logic [3:0] cnt_reg;

    always_ff @(posedge cp) begin
        if (rd) begin
            state_reg <= IDLE;
            pat_reg   <= 8'd0;
            pend_reg  <= 1'b0;
            phase_reg <= 1'b0;
            x_reg     <= 1'b0;
            step_reg  <= 1'b0;
            clr_reg   <= 1'b0;
            idx_reg   <= 3'd7;
            cnt_reg   <= 4'd0;
        end else begin
            step_reg <= 1'b0;
            clr_reg  <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        pat_reg   <= pattern;
                        cnt_reg   <= 4'd0;
                        idx_reg   <= 3'd7;
                        pend_reg  <= 1'b0;
                        phase_reg <= 1'b0;
                        clr_reg   <= 1'b1;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    // A sample spans two cycles: the step cycle, then the cycle
                    // in which the detector's updated output is sampled.
                    if (!pend_reg) begin
                        if (tick) begin
                            x_reg     <= pat_reg[idx_reg];
                            step_reg  <= 1'b1;
                            pend_reg  <= 1'b1;
                            phase_reg <= 1'b0;
                        end
                    end else if (!phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        pend_reg  <= 1'b0;
                        phase_reg <= 1'b0;
                        if (z_in && (cnt_reg != 4'd8)) begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                        if (idx_reg == 3'd0) begin
                            state_reg <= DONE;
                        end else begin
                            idx_reg <= idx_reg - 3'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign x         = x_reg;
    assign det_step  = step_reg;
    assign det_clr   = clr_reg;
    assign bit_idx   = idx_reg;
    assign match_cnt = cnt_reg;
    assign busy      = (state_reg == CLEAR) || (state_reg == RUN);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl, with an overlapping "101" Moore detector
// model stepped by det_step and cleared by det_clr.
module tb_seq_detect_ctrl;

    logic       cp = 1'b0;
    logic       rd = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       z_in;
    logic       x;
    logic       det_step;
    logic       det_clr;
    logic       busy;
    logic       done;
    logic [2:0] bit_idx;
    logic [3:0] match_cnt;

    int errors = 0;
    int checks = 0;
    int nsteps = 0;

    seq_detect_ctrl dut (
        .cp(cp), .rd(rd), .start(start), .tick(tick), .pattern(pattern),
        .z_in(z_in), .x(x), .det_step(det_step), .det_clr(det_clr),
        .busy(busy), .done(done), .bit_idx(bit_idx), .match_cnt(match_cnt)
    );

    always #5 cp = ~cp;

    // Detector states: 0 none, 1 saw "1", 2 saw "10", 3 saw "101" (z=1)
    logic [1:0] dstate = 2'd0;
    assign z_in = (dstate == 2'd3);

    always @(posedge cp) begin
        if (rd || det_clr) begin
            dstate <= 2'd0;
        end else if (det_step) begin
            case (dstate)
                2'd0: dstate <= x ? 2'd1 : 2'd0;
                2'd1: dstate <= x ? 2'd1 : 2'd2;
                2'd2: dstate <= x ? 2'd3 : 2'd0;
                default: dstate <= x ? 2'd1 : 2'd2;
            endcase
        end
    end

    always @(posedge cp) begin
        if (det_step === 1'b1) nsteps <= nsteps + 1;
    end

    task automatic cyc();
        @(posedge cp);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_start(input logic [7:0] p);
        pattern = p;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_det_clr", det_clr, 1);
        chk("start_busy", busy, 1);
        chk("start_cnt", match_cnt, 0);
        chk("start_idx", bit_idx, 7);
        cyc();
        chk("clear_one_cycle", det_clr, 0);
    endtask

    task automatic run_spaced(input logic [7:0] p, input int mid, input logic [3:0] exp_cnt);
        int s0;
        do_start(p);
        s0 = nsteps;
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk("step_pulse", det_step, 1);
            chk("x_bit", x, p[7-i]);
            for (int j = 0; j < 3; j++) begin
                if (i == mid && j == 1) begin
                    pattern = 8'hFF;
                    start = 1'b1;
                end
                cyc();
                start = 1'b0;
                if (j == 0) chk("step_one_cycle", det_step, 0);
                if (i == mid && j == 1) chk("start_ignored_in_run", det_clr, 0);
            end
        end
        chk("run_done", done, 1);
        chk("run_not_busy", busy, 0);
        chk("run_cnt", match_cnt, exp_cnt);
        chk("run_steps", nsteps - s0, 8);
        $display("run pattern=%h mid_start=%0d match_cnt=%0d steps=%0d", p, mid, match_cnt, nsteps - s0);
    endtask

    initial begin
        int s0;
        int c;

        // Reset state
        repeat (3) cyc();
        chk("rst_x", x, 0);
        chk("rst_step", det_step, 0);
        chk("rst_clr", det_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", bit_idx, 7);
        chk("rst_cnt", match_cnt, 0);

        // Reset wins over start and tick
        start = 1'b1;
        tick = 1'b1;
        cyc();
        rd = 1'b0;
        start = 1'b0;
        tick = 1'b0;
        chk("rd_prio_busy", busy, 0);
        chk("rd_prio_clr", det_clr, 0);
        $display("reset with start/tick busy=%0d", busy);

        // Tick in IDLE does nothing
        s0 = nsteps;
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        chk("idle_tick_steps", nsteps - s0, 0);
        chk("idle_tick_busy", busy, 0);

        // 0xA8: x = 1,0,1,0,1,0,0,0 -> two hits
        run_spaced(8'hA8, -1, 4'd2);

        // DONE holds against ticks
        tick = 1'b1;
        repeat (4) cyc();
        tick = 1'b0;
        chk("done_hold_cnt", match_cnt, 2);
        chk("done_hold_done", done, 1);

        // Restart from DONE
        run_spaced(8'h55, -1, 4'd3);
        run_spaced(8'hFF, -1, 4'd0);

        // Start with a new pattern mid-run is ignored
        run_spaced(8'h55, 2, 4'd3);

        // Tick held high: one accepted every third cycle
        do_start(8'hA8);
        s0 = nsteps;
        tick = 1'b1;
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            cyc();
            c++;
        end
        chk("burst_cycles", c, 24);
        chk("burst_steps", nsteps - s0, 8);
        chk("burst_cnt", match_cnt, 2);
        repeat (6) cyc();
        tick = 1'b0;
        chk("burst_no_extra", nsteps - s0, 8);
        $display("burst pattern=a8 cycles=%0d steps=%0d match_cnt=%0d", c, nsteps - s0, match_cnt);

        // Abort after the 4th step
        do_start(8'hA8);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i < 3) repeat (3) cyc();
        end
        chk("abort_step4", det_step, 1);
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", match_cnt, 0);
        chk("abort_idx", bit_idx, 7);
        chk("abort_x", x, 0);
        chk("abort_step", det_step, 0);
        s0 = nsteps;
        tick = 1'b1;
        repeat (20) cyc();
        tick = 1'b0;
        chk("abort_no_steps", nsteps - s0, 0);
        $display("abort after 4 steps busy=%0d match_cnt=%0d", busy, match_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
